// File: rtl/spi_regfile_peripheral.sv
// SPI register-file target: oversampled SPI (CPHA=0) decoding one R/W+ADDR+DATA frame per nCS window.
// Optional CIPO readback is enabled by defining SPI_READBACK_EN.
module spi_regfile_peripheral #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 5,
  parameter int CPOL = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk_i,
  input  logic                       ncs_i,
  input  logic                       copi_i,
  output logic                       cipo_o,
  output logic                       cipo_oe_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_stb_o,
  output logic [ADDR_W-1:0]          wr_addr_o
);

  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 2);
  localparam logic SCLK_IDLE = (CPOL != 0);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME-1:0]   sr;
  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic               armed, settled;
  logic               sclk_s1, sclk_s2, sclk_s3;
  logic               ncs_s1, ncs_s2, ncs_s3;
  logic               copi_s1, copi_s2;

  logic sclk_edge, lead, trail, ncs_fall, ncs_rise;
  assign sclk_edge = sclk_s2 ^ sclk_s3;
  assign lead      = sclk_edge && (sclk_s2 != SCLK_IDLE);
  assign trail     = sclk_edge && (sclk_s2 == SCLK_IDLE);
  assign ncs_fall  = !ncs_s2 && ncs_s3;
  assign ncs_rise  = ncs_s2 && !ncs_s3;

  // Frame fields once the full frame has been shifted in.
  logic              f_rw;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;
  logic              commit_ok;
  assign f_rw      = sr[FRAME-1];
  assign f_addr    = sr[FRAME-2 -: ADDR_W];
  assign f_data    = sr[DATA_W-1:0];
  assign commit_ok = (state == DONE) && (cnt == CNT_W'(FRAME)) && f_rw &&
                     ({1'b0, f_addr} < (ADDR_W+1)'(NUM_REGS));

`ifdef SPI_READBACK_EN
  // Address/R-W as they will stand after the incoming (last address) bit is shifted in.
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rw;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] sout;
  assign rd_addr = {sr[ADDR_W-2:0], copi_s2};
  assign rd_rw   = sr[ADDR_W-1];

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (rd_addr == ADDR_W'(k)) rd_data = regs[k];
  end

  assign cipo_o    = sout[DATA_W-1];
  assign cipo_oe_o = !ncs_s2;
`else
  assign cipo_o    = 1'b0;
  assign cipo_oe_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_s1   <= SCLK_IDLE;
      sclk_s2   <= SCLK_IDLE;
      sclk_s3   <= SCLK_IDLE;
      ncs_s1    <= 1'b1;
      ncs_s2    <= 1'b1;
      ncs_s3    <= 1'b1;
      copi_s1   <= 1'b0;
      copi_s2   <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      armed     <= 1'b0;
      settled   <= 1'b0;
      wr_stb_o  <= 1'b0;
      wr_addr_o <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
`ifdef SPI_READBACK_EN
      sout      <= '0;
`endif
    end else begin
      sclk_s1 <= sclk_i;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      ncs_s1  <= ncs_i;
      ncs_s2  <= ncs_s1;
      ncs_s3  <= ncs_s2;
      copi_s1 <= copi_i;
      copi_s2 <= copi_s1;
      // The sync flops hold their reset value for one cycle; only arm on a real high sample.
      settled <= 1'b1;
      if (settled && ncs_s1 && ncs_s2) armed <= 1'b1;
      wr_stb_o <= 1'b0;

      if (ncs_rise) begin
        if (commit_ok) begin
          for (int k = 0; k < NUM_REGS; k++)
            if (f_addr == ADDR_W'(k)) regs[k] <= f_data;
          wr_addr_o <= f_addr;
          wr_stb_o  <= 1'b1;
        end
        state <= IDLE;
        cnt   <= '0;
`ifdef SPI_READBACK_EN
        sout  <= '0;
`endif
      end else if (ncs_fall) begin
        if (armed) begin
          state <= ADDR;
          cnt   <= '0;
          sr    <= '0;
        end
`ifdef SPI_READBACK_EN
        sout <= '0;
`endif
      end else if (state != IDLE) begin
        if (lead) begin
          sr <= {sr[FRAME-2:0], copi_s2};
          if (cnt != CNT_W'(FRAME + 1)) cnt <= cnt + CNT_W'(1);
          case (state)
            ADDR:    if (cnt == CNT_W'(ADDR_W)) state <= DATA;
            DATA:    if (cnt == CNT_W'(FRAME - 1)) state <= DONE;
            default: ;
          endcase
`ifdef SPI_READBACK_EN
          if (state == ADDR && cnt == CNT_W'(ADDR_W) && !rd_rw) sout <= rd_data;
`endif
        end
`ifdef SPI_READBACK_EN
        // MSB is presented straight after loading; shifting starts once it has been sampled.
        else if (trail && cnt >= CNT_W'(ADDR_W + 2)) begin
          sout <= {sout[DATA_W-2:0], 1'b0};
        end
`endif
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral: an SPI driver issues frames, a strobe monitor
// checks committed writes against an expected queue, and the register file is compared to a model.
module tb_spi_regfile_peripheral;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int NUM_REGS = 5;
  localparam int HALF = 4;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic ncs = 1'b1;
  logic copi = 1'b0;
  logic cipo, cipo_oe, wr_stb;
  logic [NUM_REGS*DATA_W-1:0] regs;
  logic [ADDR_W-1:0] wr_addr;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] model [NUM_REGS];

  spi_regfile_peripheral #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .CPOL(0), .RESET_VAL('0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk_i(sclk), .ncs_i(ncs), .copi_i(copi),
    .cipo_o(cipo), .cipo_oe_o(cipo_oe), .regs_o(regs),
    .wr_stb_o(wr_stb), .wr_addr_o(wr_addr)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] model_vec();
    logic [NUM_REGS*DATA_W-1:0] v;
    for (int k = 0; k < NUM_REGS; k++) v[k*DATA_W +: DATA_W] = model[k];
    return v;
  endfunction

  // Driver: nbits MSB first from bits[nbits-1:0]; optional reset pulse before bit rst_at.
  task automatic spi_frame(input int nbits, input logic [31:0] bits, input int rst_at,
                           output logic [DATA_W-1:0] rd, output logic oe_mid);
    rd = '0;
    oe_mid = 1'b0;
    ncs = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        wait_clks(2);
        rst_n = 1'b1;
      end
      copi = bits[nbits-1-i];
      wait_clks(HALF);
      if (i == 4) oe_mid = cipo_oe;
      if (nbits == 1 + ADDR_W + DATA_W && i > ADDR_W) rd = {rd[DATA_W-2:0], cipo};
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
    end
    wait_clks(HALF);
    ncs = 1'b1;
    copi = 1'b0;
    wait_clks(10);
  endtask

  // Monitor: every strobe pops one expected {addr,data}
  always @(negedge clk) begin
    if (rst_n && wr_stb) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got addr %0d expected no strobe", wr_addr);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("strobe_addr", 64'(wr_addr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
        check("strobe_data", 64'(regs[int'(e[ADDR_W+DATA_W-1:DATA_W])*DATA_W +: DATA_W]),
              64'(e[DATA_W-1:0]));
      end
    end
  end

  // Watchdog
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [DATA_W-1:0] rd;
    logic oe;
    logic exp_oe;
`ifdef SPI_READBACK_EN
    exp_oe = 1'b1;
`else
    exp_oe = 1'b0;
`endif
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;

    // 1: reset
    rst_n = 1'b0;
    wait_clks(2);
    check("reset_regs", 64'(regs), 64'(0));
    check("reset_stb", 64'(wr_stb), 64'(0));
    check("reset_oe", 64'(cipo_oe), 64'(0));
    check("reset_addr", 64'(wr_addr), 64'(0));
    rst_n = 1'b1;
    wait_clks(5);

    // 2: write reg2 = 0xA5
    exp_q.push_back({7'd2, 8'hA5});
    model[2] = 8'hA5;
    spi_frame(16, 32'h82A5, -1, rd, oe);
    check("w2_regs", 64'(regs), 64'(model_vec()));
    check("w2_oe_mid", 64'(oe), 64'(exp_oe));

    // 3: short and long frames to addr0
    spi_frame(15, 32'h805A >> 1, -1, rd, oe);
    check("short_regs", 64'(regs), 64'(model_vec()));
    spi_frame(17, {15'd0, 16'h805A, 1'b1}, -1, rd, oe);
    check("long_regs", 64'(regs), 64'(model_vec()));

    // 4: out-of-range write and a read frame
    spi_frame(16, 32'h8577, -1, rd, oe);
    check("oor_regs", 64'(regs), 64'(model_vec()));
    spi_frame(16, 32'h0133, -1, rd, oe);
    check("read_regs", 64'(regs), 64'(model_vec()));

    // more writes at the register-range boundaries
    exp_q.push_back({7'd0, 8'hFF});
    model[0] = 8'hFF;
    spi_frame(16, 32'h80FF, -1, rd, oe);
    exp_q.push_back({7'd4, 8'h81});
    model[4] = 8'h81;
    spi_frame(16, 32'h8481, -1, rd, oe);
    check("edges_regs", 64'(regs), 64'(model_vec()));

    // 5: reset mid-frame, then a full frame
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    spi_frame(16, 32'h8111, 8, rd, oe);
    check("midrst_regs", 64'(regs), 64'(model_vec()));
    exp_q.push_back({7'd4, 8'hC3});
    model[4] = 8'hC3;
    spi_frame(16, 32'h84C3, -1, rd, oe);
    check("after_rst_regs", 64'(regs), 64'(model_vec()));

`ifdef SPI_READBACK_EN
    // 6: readback
    exp_q.push_back({7'd3, 8'h3C});
    model[3] = 8'h3C;
    spi_frame(16, 32'h833C, -1, rd, oe);
    spi_frame(16, 32'h0300, -1, rd, oe);
    check("rd_addr3", 64'(rd), 64'(8'h3C));
    spi_frame(16, 32'h0400, -1, rd, oe);
    check("rd_addr4", 64'(rd), 64'(8'hC3));
    spi_frame(16, 32'h7F00, -1, rd, oe);
    check("rd_addr7f", 64'(rd), 64'(8'h00));
    check("rd_regs", 64'(regs), 64'(model_vec()));
`endif

    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
